// File: rtl/connect_pkg.sv
// Shared NoC flit/credit types and sizing for the ingress credit FIFO.
package connect_pkg;
  localparam int FLIT_WIDTH  = 40;
  localparam int DEST_BITS   = 2;
  localparam int VC_BITS     = 1;
  localparam int NUM_VCS     = 2 ** VC_BITS;
  localparam int DEPTH       = 4;
  localparam int CREDIT_INIT = 4;
  localparam int CNT_W       = $clog2(CREDIT_INIT + 1);
  localparam int DATA_BITS   = FLIT_WIDTH - 2 - DEST_BITS - VC_BITS;

  typedef struct packed {
    logic                 valid;
    logic                 is_tail;
    logic [DEST_BITS-1:0] dst;
    logic [VC_BITS-1:0]   vc;
    logic [DATA_BITS-1:0] data;
  } flit_t;

  typedef struct packed {
    logic               valid;
    logic [VC_BITS-1:0] vc;
  } credit_t;

  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/flit_sync_fifo.sv
// Synchronous flit FIFO with wrap-bit pointers and a combinational head.
module flit_sync_fifo
  import connect_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  flit_t wdata,
  output flit_t head,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);

  flit_t          mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/in_port_credit_fifo.sv
// NoC send-port ingress buffer with per-VC credit flow control.
// Optional IN_PORT_TRACE_EN macro enables per-cycle send/credit trace.
module in_port_credit_fifo
  import connect_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [FLIT_WIDTH-1:0] put_flit,
  input  logic                  put_flit_valid,
  output logic                  put_flit_ready,
  output logic [FLIT_WIDTH-1:0] send_ports_putFlit_flit_in,
  output logic                  EN_send_ports_putFlit,
  input  logic [VC_BITS:0]      send_ports_getCredits,
  output logic                  EN_send_ports_getCredits
);
  flit_t              head;
  logic               full;
  logic               empty;
  logic               push;
  logic               send;
  credit_t            cr;
  cnt_t               credit [NUM_VCS];
  logic [NUM_VCS-1:0] inc;
  logic [NUM_VCS-1:0] dec;

  // RST_N is active-high; all strobes are held low while it is asserted.
  assign cr             = credit_t'(send_ports_getCredits);
  assign put_flit_ready = !RST_N && !full;
  assign push           = put_flit_valid && put_flit_ready;
  assign send           = !RST_N && !empty && (credit[head.vc] != '0);

  assign EN_send_ports_putFlit    = send;
  assign EN_send_ports_getCredits = !RST_N;

  always_comb begin
    send_ports_putFlit_flit_in = '0;
    if (send) begin
      send_ports_putFlit_flit_in = head;
      send_ports_putFlit_flit_in[FLIT_WIDTH-1] = 1'b1;
    end
  end

  flit_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST_N),
    .push  (push),
    .pop   (send),
    .wdata (flit_t'(put_flit)),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    inc = '0;
    dec = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      inc[v] = !RST_N && cr.valid && (cr.vc == VC_BITS'(v));
      dec[v] = send && (head.vc == VC_BITS'(v));
    end
  end

  // Same-VC send and return cancel; over-return saturates.
  always_ff @(posedge CLK) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (RST_N) begin
        credit[v] <= cnt_t'(CREDIT_INIT);
      end else if (inc[v] && !dec[v]) begin
        if (credit[v] != cnt_t'(CREDIT_INIT))
          credit[v] <= credit[v] + 1'b1;
      end else if (dec[v] && !inc[v]) begin
        credit[v] <= credit[v] - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (inc[v] && !dec[v] && credit[v] == cnt_t'(CREDIT_INIT))
        $error("credit overflow on vc %0d", v);
    end
  end
`endif

`ifdef IN_PORT_TRACE_EN
  logic [15:0] cycle;

  always_ff @(posedge CLK) begin
    if (RST_N) cycle <= '0;
    else       cycle <= cycle + 1'b1;
    if (send)
      $display("%d: send flit %x", cycle, send_ports_putFlit_flit_in);
    if (!RST_N && cr.valid)
      $display("%d: get a credit vc %0d", cycle, cr.vc);
  end
`endif
endmodule

// File: tb/tb_in_port_credit_fifo.sv
// Scoreboard bench for in_port_credit_fifo: queue/credit reference model.
module tb_in_port_credit_fifo;
  logic        CLK;
  logic        RST_N;
  logic [39:0] put_flit;
  logic        put_flit_valid;
  logic        put_flit_ready;
  logic [39:0] flit_in;
  logic        en_put;
  logic [1:0]  get_cr;
  logic        en_cr;

  in_port_credit_fifo dut (
    .CLK                        (CLK),
    .RST_N                      (RST_N),
    .put_flit                   (put_flit),
    .put_flit_valid             (put_flit_valid),
    .put_flit_ready             (put_flit_ready),
    .send_ports_putFlit_flit_in (flit_in),
    .EN_send_ports_putFlit      (en_put),
    .send_ports_getCredits      (get_cr),
    .EN_send_ports_getCredits   (en_cr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  logic [39:0] q[$];
  int          cred[2] = '{4, 4};
  logic        rdy_s = 1'b0;
  logic        sent = 1'b0;
  int          sent_vc = 0;
  int          n_model = 0;
  int          n_dut = 0;

  task automatic chk(input string n, input logic [39:0] a,
                     input logic [39:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [39:0] mk(input int v, input int d,
                                     input logic [34:0] data);
    logic [39:0] f;
    f = {1'b0, 1'b0, d[1:0], v[0], data};
    return f;
  endfunction

  // Monitor: compare DUT outputs with the model mid-cycle.
  always @(negedge CLK) begin
    logic        e_en;
    logic        e_rdy;
    logic        e_cr;
    logic [39:0] ef;
    rdy_s = put_flit_ready;
    if (en_put === 1'b1) n_dut++;
    e_en = 1'b0;
    e_rdy = 1'b0;
    e_cr = 1'b0;
    if (!RST_N) begin
      e_cr = 1'b1;
      e_rdy = (q.size() < 4);
      if (q.size() > 0) e_en = (cred[int'(q[0][35])] > 0);
    end
    chk("send_en", {39'd0, en_put}, {39'd0, e_en});
    chk("ready", {39'd0, put_flit_ready}, {39'd0, e_rdy});
    chk("credit_en", {39'd0, en_cr}, {39'd0, e_cr});
    sent = 1'b0;
    if (e_en) begin
      ef = q.pop_front();
      chk("flit", flit_in, ef);
      sent = 1'b1;
      sent_vc = int'(ef[35]);
      n_model++;
    end else begin
      chk("idle_flit", flit_in, 40'd0);
    end
  end

  // Model update at the clock edge using the applied inputs.
  always @(posedge CLK) begin
    logic [39:0] f;
    if (RST_N) begin
      q.delete();
      cred[0] = 4;
      cred[1] = 4;
    end else begin
      if (sent) cred[sent_vc]--;
      if (get_cr[1]) cred[int'(get_cr[0])]++;
      if (put_flit_valid && rdy_s) begin
        f = put_flit;
        f[39] = 1'b1;
        q.push_back(f);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic put(input logic [39:0] f);
    logic acc;
    put_flit = f;
    put_flit_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      acc = put_flit_ready;
      step();
      if (acc) begin
        put_flit_valid = 1'b0;
        return;
      end
    end
    put_flit_valid = 1'b0;
    total++;
    bad++;
    $display("FAIL put_timeout: got no accept want accept");
  endtask

  task automatic ret(input int v);
    get_cr = {1'b1, v[0]};
    step();
    get_cr = 2'b00;
  endtask

  task automatic restore();
    int v;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && cred[0] == 4 && cred[1] == 4) begin
        get_cr = 2'b00;
        step();
        return;
      end
      v = i % 2;
      if (cred[v] >= 4) v = 1 - v;
      if (cred[v] < 4) get_cr = {1'b1, v[0]};
      else get_cr = 2'b00;
      step();
    end
    get_cr = 2'b00;
    total++;
    bad++;
    $display("FAIL restore_timeout: got busy want drained");
  endtask

  initial begin
    int base;
    int cnt;
    logic acc;
    logic [39:0] f;
    RST_N = 1'b1;
    put_flit = '0;
    put_flit_valid = 1'b0;
    get_cr = 2'b00;
    steps(3);
    chk("rst_ready", {39'd0, put_flit_ready}, 40'd0);
    chk("rst_en", {39'd0, en_put}, 40'd0);
    RST_N = 1'b0;
    step();
    chk("post_rst_ready", {39'd0, put_flit_ready}, 40'd1);

    // 1: single flit, one-cycle latency, MSB forced
    put(mk(0, 2, 35'h5));
    chk("t1_en", {39'd0, en_put}, 40'd1);
    chk("t1_flit", flit_in, {1'b1, 1'b0, 2'd2, 1'b0, 35'h5});
    restore();

    // 2: five vc0 flits, four credits
    base = n_dut;
    for (int i = 0; i < 5; i++) put(mk(0, i, 35'(i + 16)));
    steps(5);
    chk("t2_sent4", 40'(n_dut - base), 40'd4);
    chk("t2_held", {39'd0, en_put}, 40'd0);
    ret(0);
    chk("t2_fifth", {39'd0, en_put}, 40'd1);
    step();

    // 3: credits at zero, fill to DEPTH
    cnt = 0;
    put_flit_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put_flit = mk(0, 1, 35'(i + 32));
      acc = put_flit_ready;
      step();
      if (acc) cnt++;
    end
    put_flit_valid = 1'b0;
    chk("t3_accepts", 40'(cnt), 40'd4);
    chk("t3_full", {39'd0, put_flit_ready}, 40'd0);
    ret(0);
    step();
    chk("t3_ready_back", {39'd0, put_flit_ready}, 40'd1);
    restore();

    // 4: same-vc send and return cancel
    base = n_dut;
    put(mk(1, 3, 35'h77));
    get_cr = 2'b11;
    step();
    get_cr = 2'b00;
    for (int i = 0; i < 4; i++) put(mk(1, 0, 35'(i + 48)));
    steps(3);
    chk("t4_sent5", 40'(n_dut - base), 40'd5);
    restore();
    base = n_dut;
    for (int i = 0; i < 8; i++) put(mk(i % 2, 1, 35'(i + 64)));
    steps(3);
    chk("t4_restored", 40'(n_dut - base), 40'd8);
    restore();

    // 5: head-of-line blocking
    base = n_dut;
    for (int i = 0; i < 4; i++) put(mk(0, 2, 35'(i + 80)));
    steps(3);
    put(mk(0, 1, 35'h5a));
    put(mk(1, 2, 35'h5b));
    steps(4);
    chk("t5_blocked", {39'd0, en_put}, 40'd0);
    chk("t5_sent4", 40'(n_dut - base), 40'd4);
    ret(0);
    chk("t5_vc0", {39'd0, en_put}, 40'd1);
    step();
    chk("t5_vc1", {39'd0, en_put, flit_in[35]}, 40'd3);
    restore();

    // 6: reset with flits queued
    for (int i = 0; i < 4; i++) put(mk(0, 0, 35'(i + 96)));
    steps(3);
    for (int i = 0; i < 3; i++) put(mk(0, 3, 35'(i + 112)));
    RST_N = 1'b1;
    step();
    chk("t6_en", {39'd0, en_put}, 40'd0);
    chk("t6_ready", {39'd0, put_flit_ready}, 40'd0);
    chk("t6_cr_en", {39'd0, en_cr}, 40'd0);
    RST_N = 1'b0;
    step();
    chk("t6_ready_rel", {39'd0, put_flit_ready}, 40'd1);
    base = n_dut;
    steps(4);
    chk("t6_no_stale", 40'(n_dut - base), 40'd0);
    for (int i = 0; i < 4; i++) put(mk(0, 1, 35'(i + 128)));
    steps(3);
    chk("t6_credits4", 40'(n_dut - base), 40'd4);
    restore();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      int v;
      put_flit_valid = ($urandom_range(0, 2) != 0);
      f = {$urandom, $urandom};
      put_flit = f;
      get_cr = 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom_range(0, 1);
        if (cred[v] < 4) get_cr = {1'b1, v[0]};
      end
      RST_N = ($urandom_range(0, 499) == 0);
      step();
    end
    put_flit_valid = 1'b0;
    RST_N = 1'b0;
    get_cr = 2'b00;
    step();
    restore();
    steps(2);
    chk("end_idle", {39'd0, en_put}, 40'd0);
    chk("end_ready", {39'd0, put_flit_ready}, 40'd1);
    chk("send_count", 40'(n_dut), 40'(n_model));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
